// File: rtl/booth_mult_unit.sv
// Sequential signed NxN radix-2 Booth multiplier: one add/sub plus one
// arithmetic shift per clock, result latched into `product` on the final step.
module booth_mult_unit #(
  parameter int N  = 32,
  parameter int SW = 6
) (
  input  logic           Clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic           busy,
  output logic           done,
  output logic [SW-1:0]  step,
  output logic [2*N-1:0] product
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   m_q, m_d;
  logic [N:0]     acc_q, acc_d;
  logic [N-1:0]   q_q, q_d;
  logic           qm1_q, qm1_d;
  logic [SW-1:0]  step_q, step_d;
  logic [2*N-1:0] product_q, product_d;

  logic [N:0]     m_ext;
  logic [N:0]     sum;
  logic [N:0]     acc_sh;
  logic [N-1:0]   q_sh;

  // Accumulator is one bit wider than M so -2^(N-1) never overflows.
  assign m_ext = {m_q[N-1], m_q};

  always_comb begin
    sum = acc_q;
    case ({q_q[0], qm1_q})
      2'b01:   sum = acc_q + m_ext;
      2'b10:   sum = acc_q - m_ext;
      default: sum = acc_q;
    endcase
    acc_sh = {sum[N], sum[N:1]};
    q_sh   = {sum[0], q_q[N-1:1]};
  end

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    acc_d     = acc_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    step_d    = step_q;
    product_d = product_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          m_d     = multiplicand;
          acc_d   = '0;
          q_d     = multiplier;
          qm1_d   = 1'b0;
          step_d  = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d  = acc_sh;
        q_d    = q_sh;
        qm1_d  = q_q[0];
        step_d = step_q + 1'b1;
        // Final step: capture the shifted pair directly as the result.
        if (step_q == SW'(N - 1)) begin
          state_d   = ST_DONE;
          product_d = {acc_sh[N-1:0], q_sh};
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      m_q       <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      step_q    <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      step_q    <= step_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == ST_RUN);
  assign done    = (state_q == ST_DONE);
  assign step    = step_q;
  assign product = product_q;

endmodule

// File: tb/tb_booth_mult_unit.sv
// Randomized self-checking bench for booth_mult_unit against a plain
// signed-multiply reference.
module tb_booth_mult_unit;

  localparam int N = 32;

  logic        Clk;
  logic        reset;
  logic        start;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic        busy;
  logic        done;
  logic [5:0]  step;
  logic [63:0] product;

  int n_checks = 0;
  int n_errors = 0;
  int cycle    = 0;

  booth_mult_unit #(.N(32), .SW(6)) dut (
    .Clk          (Clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (mcand),
    .multiplier   (mplier),
    .busy         (busy),
    .done         (done),
    .step         (step),
    .product      (product)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cycle <= cycle + 1;

  function automatic logic [63:0] ref_mult(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    return sa * sb;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Launch one multiply from IDLE and check the full timing of the operation.
  task automatic do_mult(input logic [31:0] a, input logic [31:0] b);
    int n;
    logic [63:0] exp;
    exp = ref_mult(a, b);
    @(negedge Clk);
    start = 1'b1; mcand = a; mplier = b;
    @(posedge Clk); #1;
    start = 1'b0; mcand = $urandom; mplier = $urandom;
    check_eq("busy_after_start", 64'(busy), 64'd1);
    check_eq("step_after_start", 64'(step), 64'd0);
    n = 0;
    while (!done && n < 100) begin
      @(posedge Clk); #1;
      n++;
    end
    check_eq("latency", 64'(n), 64'(N));
    check_eq("product", product, exp);
    check_eq("step_in_done", 64'(step), 64'd32);
    check_eq("busy_in_done", 64'(busy), 64'd0);
    @(posedge Clk); #1;
    check_eq("done_one_cycle", 64'(done), 64'd0);
    check_eq("product_hold", product, exp);
    $display("op %h * %h -> %h (exp %h) latency %0d", a, b, product, exp, n);
  endtask

  initial begin
    int n;
    int dones;
    int busies;
    int last_done;
    logic [31:0] ha [4];
    logic [31:0] hb [4];

    reset = 1'b1; start = 1'b0; mcand = '0; mplier = '0;
    #1;
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_step", 64'(step), 64'd0);
    check_eq("rst_product", product, 64'd0);
    repeat (2) @(posedge Clk);
    @(negedge Clk); reset = 1'b0;

    // Directed cases
    do_mult(32'd3, 32'd5);
    check_eq("dir_3x5", product, 64'h0000_0000_0000_000F);
    do_mult(32'hFFFF_FFF9, 32'd6);
    check_eq("dir_m7x6", product, 64'hFFFF_FFFF_FFFF_FFD6);
    do_mult(32'd0, 32'hDEAD_BEEF);
    check_eq("dir_0xq", product, 64'd0);
    do_mult(32'h8000_0000, 32'h8000_0000);
    check_eq("dir_min_min", product, 64'h4000_0000_0000_0000);
    do_mult(32'h7FFF_FFFF, 32'h7FFF_FFFF);
    check_eq("dir_max_max", product, 64'h3FFF_FFFF_0000_0001);
    do_mult(32'h8000_0000, 32'd1);
    check_eq("dir_min_1", product, 64'hFFFF_FFFF_8000_0000);

    // Random operands
    for (int i = 0; i < 24; i++) begin
      do_mult($urandom, $urandom);
    end

    // Start pulsed during RUN must be ignored
    @(negedge Clk);
    start = 1'b1; mcand = 32'd2; mplier = 32'd3;
    @(posedge Clk); #1;
    start = 1'b0; mcand = $urandom; mplier = $urandom;
    n = 0;
    while (step != 6'd10 && n < 100) begin
      @(posedge Clk); #1;
      n++;
    end
    check_eq("ign_reach_step10", 64'(step), 64'd10);
    start = 1'b1; mcand = 32'd9; mplier = 32'd9;
    @(posedge Clk); #1;
    start = 1'b0; mcand = $urandom; mplier = $urandom;
    n = 0;
    while (!done && n < 100) begin
      @(posedge Clk); #1;
      n++;
    end
    check_eq("ign_product", product, 64'd6);
    dones = 0; busies = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clk); #1;
      if (done) dones++;
      if (busy) busies++;
    end
    check_eq("ign_no_extra_done", 64'(dones), 64'd0);
    check_eq("ign_not_queued", 64'(busies), 64'd0);
    $display("op 2 * 3 with ignored start -> %h", product);
    do_mult(32'd9, 32'd9);
    check_eq("ign_9x9", product, 64'd81);

    // Asynchronous reset mid-run
    @(negedge Clk);
    start = 1'b1; mcand = $urandom; mplier = $urandom;
    @(posedge Clk); #1;
    start = 1'b0;
    n = 0;
    while (step != 6'd17 && n < 100) begin
      @(posedge Clk); #1;
      n++;
    end
    check_eq("arst_reach_step17", 64'(step), 64'd17);
    #2 reset = 1'b1;
    #1;
    check_eq("arst_busy", 64'(busy), 64'd0);
    check_eq("arst_done", 64'(done), 64'd0);
    check_eq("arst_step", 64'(step), 64'd0);
    check_eq("arst_product", product, 64'd0);
    dones = 0;
    repeat (3) begin
      @(posedge Clk); #1;
      if (done) dones++;
    end
    @(negedge Clk); reset = 1'b0;
    repeat (40) begin
      @(posedge Clk); #1;
      if (done) dones++;
    end
    check_eq("arst_no_done", 64'(dones), 64'd0);
    $display("async reset at step 17 -> product %h", product);
    do_mult(32'd4, 32'd4);
    check_eq("arst_4x4", product, 64'd16);

    // Start held high: back-to-back operations
    for (int i = 0; i < 4; i++) begin
      ha[i] = $urandom; hb[i] = $urandom;
    end
    last_done = 0;
    @(negedge Clk);
    start = 1'b1; mcand = ha[0]; mplier = hb[0];
    for (int i = 0; i < 3; i++) begin
      n = 0;
      do begin
        @(posedge Clk); #1;
        n++;
      end while (!busy && n < 100);
      check_eq("hold_accept", 64'(busy), 64'd1);
      mcand = ha[i+1]; mplier = hb[i+1];
      n = 0;
      while (!done && n < 100) begin
        @(posedge Clk); #1;
        n++;
      end
      if (i == 2) start = 1'b0;
      check_eq("hold_product", product, ref_mult(ha[i], hb[i]));
      check_eq("hold_step32", 64'(step), 64'd32);
      if (i > 0) check_eq("hold_spacing", 64'(cycle - last_done), 64'(N + 2));
      $display("held op %0d: %h * %h -> %h at cycle %0d", i, ha[i], hb[i], product, cycle);
      last_done = cycle;
      @(posedge Clk); #1;
      check_eq("hold_done_pulse", 64'(done), 64'd0);
    end
    repeat (3) @(posedge Clk);
    #1;
    check_eq("hold_stopped", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
